// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared register-file bus widths and constants for the write-back arbiter
package wb_arbiter_pkg;
  localparam int REG_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic [REG_W-1:0] ZERO_WORD = '0;
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - long-latency result queue with per-entry valid bits, address compare and invalidate
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [REG_W-1:0]      push_data,
  input  logic                  pop,
  input  logic                  inv_en,
  input  logic [REG_ADDR_W-1:0] inv_addr,
  input  logic [REG_ADDR_W-1:0] cmp_addr1,
  input  logic [REG_ADDR_W-1:0] cmp_addr2,
  output logic                  full,
  output logic                  empty,
  output logic                  head_valid,
  output logic [REG_ADDR_W-1:0] head_addr,
  output logic [REG_W-1:0]      head_data,
  output logic                  hit1,
  output logic                  hit2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]      vld;
  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [REG_W-1:0]      data_q [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign head_valid = vld[rd_ptr];
  assign head_addr  = addr_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (addr_q[i] == cmp_addr1)) hit1 = 1'b1;
      if (vld[i] && (addr_q[i] == cmp_addr2)) hit2 = 1'b1;
    end
  end

  // Invalidation is applied before the push so a same-cycle push to the same register survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (inv_en && vld[i] && (addr_q[i] == inv_addr)) vld[i] <= 1'b0;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      if (push) begin
        vld[wr_ptr]    <= 1'b1;
        addr_q[wr_ptr] <= push_addr;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-back arbiter: pipe writes first, long-latency results fill free slots
// Optional starvation guard (wb_stall, forced drain slot) enabled by defining WB_STARVE_GUARD_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int QDEPTH       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_waddr,
  input  logic [REG_W-1:0]      pipe_wdata,
  input  logic                  lt_valid,
  input  logic [REG_ADDR_W-1:0] lt_waddr,
  input  logic [REG_W-1:0]      lt_wdata,
  output logic                  lt_ready,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [REG_W-1:0]      wdata,
  input  logic [REG_ADDR_W-1:0] q_raddr1,
  input  logic [REG_ADDR_W-1:0] q_raddr2,
  output logic                  q_stall,
  output logic                  wb_stall
);
  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || STARVE_LIMIT < 2) begin : g_bad_cfg
    $error("wb_arbiter: QDEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 2");
  end

  logic                  rdy_q;
  logic                  full;
  logic                  empty;
  logic                  head_valid;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [REG_W-1:0]      head_data;
  logic                  hit1;
  logic                  hit2;
  logic                  force_drain;
  logic                  push;
  logic                  pop;
  logic                  sel_pipe;

  assign lt_ready = rdy_q && !full;
  // Results for r0 are acknowledged but never enter the queue.
  assign push     = lt_valid && lt_ready && (lt_waddr != '0);
  assign sel_pipe = pipe_we && (pipe_waddr != '0) && !(force_drain && !empty);
  assign pop      = !sel_pipe && !empty;

  wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (lt_waddr),
    .push_data (lt_wdata),
    .pop       (pop),
    .inv_en    (sel_pipe),
    .inv_addr  (pipe_waddr),
    .cmp_addr1 (q_raddr1),
    .cmp_addr2 (q_raddr2),
    .full      (full),
    .empty     (empty),
    .head_valid(head_valid),
    .head_addr (head_addr),
    .head_data (head_data),
    .hit1      (hit1),
    .hit2      (hit2)
  );

  assign q_stall = ((q_raddr1 != '0) && (hit1 || (push && (lt_waddr == q_raddr1)))) ||
                   ((q_raddr2 != '0) && (hit2 || (push && (lt_waddr == q_raddr2))));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q <= 1'b0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= ZERO_WORD;
    end else begin
      rdy_q <= 1'b1;
      if (sel_pipe) begin
        we    <= WRITE_ENABLE;
        waddr <= pipe_waddr;
        wdata <= pipe_wdata;
      end else if (pop && head_valid) begin
        we    <= WRITE_ENABLE;
        waddr <= head_addr;
        wdata <= head_data;
      end else begin
        we    <= 1'b0;
        waddr <= '0;
        wdata <= ZERO_WORD;
      end
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0] age_q;
  logic [AW-1:0] age_d;

  always_comb begin
    age_d = '0;
    if (head_valid && !empty && !pop)
      age_d = (age_q == AW'(STARVE_LIMIT)) ? age_q : age_q + AW'(1);
  end

  // Raised one count early so wb_stall is visible on the STARVE_LIMIT-th waiting cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_q       <= '0;
      wb_stall    <= 1'b0;
      force_drain <= 1'b0;
    end else begin
      age_q       <= age_d;
      wb_stall    <= (age_d == AW'(STARVE_LIMIT - 1)) && head_valid && !pop;
      force_drain <= wb_stall;
      if (force_drain) assert (!(pipe_we && (pipe_waddr != '0)));
    end
  end
`else
  assign wb_stall    = 1'b0;
  assign force_drain = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed scoreboard bench for wb_arbiter
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lt_valid;
  logic [4:0]  lt_waddr;
  logic [31:0] lt_wdata;
  logic        lt_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  q_raddr1;
  logic [4:0]  q_raddr2;
  logic        q_stall;
  logic        wb_stall;

  int total = 0;
  int bad = 0;
  logic [36:0] sb [$];

`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_arbiter #(.QDEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_waddr(pipe_waddr),
    .pipe_wdata(pipe_wdata),
    .lt_valid  (lt_valid),
    .lt_waddr  (lt_waddr),
    .lt_wdata  (lt_wdata),
    .lt_ready  (lt_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .q_raddr1  (q_raddr1),
    .q_raddr2  (q_raddr2),
    .q_stall   (q_stall),
    .wb_stall  (wb_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
    lt_valid = lv; lt_waddr = la; lt_wdata = ld;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    sb.push_back({a, d});
  endtask

  // Advance one clock and score any register-file write against the queue.
  task automatic step();
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (we !== 1'b0) begin
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wb_write", 64'({waddr, wdata}), 64'(e));
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    q_raddr1 = '0;
    q_raddr2 = '0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #3;
    check("rst_we", 64'(we), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_lt_ready", 64'(lt_ready), 64'd0);
    check("rst_wb_stall", 64'(wb_stall), 64'd0);
    check("rst_q_stall", 64'(q_stall), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rel_lt_ready_low", 64'(lt_ready), 64'd0);
    step();
    check("rel_lt_ready_high", 64'(lt_ready), 64'd1);

    // Single pipe write appears one cycle later, then idle output.
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd5, 32'h1234);
    step();
    check("t1_we", 64'(we), 64'd1);
    check("t1_waddr", 64'(waddr), 64'd5);
    check("t1_wdata", 64'(wdata), 64'h1234);
    drive(1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 32'h0);
    step();
    check("t1_r0_we", 64'(we), 64'd0);
    check("t1_r0_wdata", 64'(wdata), 64'd0);

    // Two lt results queue behind a busy pipe; queue fills, hazards reported until popped.
    q_raddr1 = 5'd3; q_raddr2 = 5'd4;
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd3, 32'h33);
    expect_wr(5'd1, 32'h100);
    #1;
    check("t2_ready0", 64'(lt_ready), 64'd1);
    check("t2_qs_accepting", 64'(q_stall), 64'd1);
    step();
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd4, 32'h44);
    expect_wr(5'd1, 32'h101);
    #1 check("t2_ready1", 64'(lt_ready), 64'd1);
    step();
    drive(1'b1, 5'd1, 32'h102, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd1, 32'h102);
    #1;
    check("t2_full_ready", 64'(lt_ready), 64'd0);
    check("t2_qs_full", 64'(q_stall), 64'd1);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd3, 32'h33);
    q_raddr2 = 5'd0;
    #1 check("t2_qs_head", 64'(q_stall), 64'd1);
    step();
    expect_wr(5'd4, 32'h44);
    #1 check("t2_qs_outreg_only", 64'(q_stall), 64'd0);
    q_raddr1 = 5'd4;
    #1 check("t2_qs_second", 64'(q_stall), 64'd1);
    step();
    check("t2_qs_drained", 64'(q_stall), 64'd0);
    check("t2_ready_after", 64'(lt_ready), 64'd1);

    // Younger pipe write to a queued register kills the queued result.
    q_raddr1 = 5'd0;
    drive(1'b1, 5'd2, 32'h200, 1'b1, 5'd9, 32'h11);
    expect_wr(5'd2, 32'h200);
    step();
    drive(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd9, 32'h22);
    q_raddr1 = 5'd9;
    #1 check("t3_qs_pending", 64'(q_stall), 64'd1);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1 check("t3_qs_invalid", 64'(q_stall), 64'd0);
    step();
    check("t3_no_stale_write", 64'(we), 64'd0);

    // lt result accepted alongside a pipe write to the same register is kept.
    q_raddr1 = 5'd6;
    drive(1'b1, 5'd6, 32'h60, 1'b1, 5'd6, 32'h66);
    expect_wr(5'd6, 32'h60);
    #1 check("t3b_qs_accept", 64'(q_stall), 64'd1);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd6, 32'h66);
    #1 check("t3b_qs_kept", 64'(q_stall), 64'd1);
    step();
    check("t3b_waddr", 64'(waddr), 64'd6);

    // lt result to r0 is accepted and dropped.
    q_raddr1 = 5'd0; q_raddr2 = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
    #1;
    check("t4_ready", 64'(lt_ready), 64'd1);
    check("t4_qs_r0", 64'(q_stall), 64'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    check("t4_no_write", 64'(we), 64'd0);
    step();

    // Head waits behind a continuously busy pipe; upstream honours wb_stall.
    q_raddr1 = 5'd7;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd1, 32'h400 + 32'(i), 1'(i == 0), 5'd7, 32'hAA);
      expect_wr(5'd1, 32'h400 + 32'(i));
      #1;
      check("t6_wb_stall", 64'(wb_stall), 64'(GUARD && (i == 4)));
      check("t6_qs", 64'(q_stall), 64'd1);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd7, 32'hAA);
    #1 check("t6_stall_off", 64'(wb_stall), 64'd0);
    step();
    check("t6_we", 64'(we), 64'd1);
    check("t6_waddr", 64'(waddr), 64'd7);
    check("t6_wdata", 64'(wdata), 64'hAA);
    drive(1'b1, 5'd1, 32'h500, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd1, 32'h500);
    #1 check("t6_qs_clear", 64'(q_stall), 64'd0);
    step();

    // Reset with two queued results drops them.
    q_raddr1 = 5'd10;
    drive(1'b1, 5'd1, 32'h300, 1'b1, 5'd10, 32'hA);
    expect_wr(5'd1, 32'h300);
    step();
    drive(1'b1, 5'd1, 32'h301, 1'b1, 5'd11, 32'hB);
    expect_wr(5'd1, 32'h301);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1 check("t5_full", 64'(lt_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("t5_rst_we", 64'(we), 64'd0);
    check("t5_rst_ready", 64'(lt_ready), 64'd0);
    check("t5_rst_qs", 64'(q_stall), 64'd0);
    step();
    #3 rst = 1'b1;
    step();
    check("t5_ready_back", 64'(lt_ready), 64'd1);
    step();
    step();
    step();
    check("t5_no_write", 64'(we), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
